// File: rtl/el2_lsu_clken_sched_pkg.sv
// Shared types and constants for the LSU clock-enable scheduler.
// The optional stats counters (LSU_CLKEN_STATS_EN) use the saturating helper below.
package el2_lsu_clken_sched_pkg;

  typedef logic [1:0] el2_lsu_clken_state_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_PARK  = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam int LSU_CLKEN_DOM_MPIPE = 0;
  localparam int LSU_CLKEN_DOM_STBUF = 1;
  localparam int LSU_CLKEN_DOM_BUS   = 2;
  localparam int LSU_CLKEN_DOM_FREE  = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/el2_lsu_clken_sched_hold.sv
// One domain's activity-hysteresis counter and its raw enable term.
module el2_lsu_clken_sched_hold #(
  parameter int HOLD_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              act_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] cfg_hold_i,
  output logic              busy_o,
  output logic              cnt_nz_o,
  output logic              next_zero_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // Saturating down-counter; clear wins so a parked domain cannot reload.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (load_i || act_i)
      cnt_d = cfg_hold_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - HOLD_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_nz_o    = |cnt_q;
  assign busy_o      = act_i | cnt_nz_o;
  assign next_zero_o = ~|cnt_d;

endmodule

// File: rtl/el2_lsu_clken_sched.sv
// LSU clock-enable scheduler: per-domain hysteresis plus quiesce/park handshake.
// Define LSU_CLKEN_STATS_EN to add per-domain saturating gated-cycle counters.
module el2_lsu_clken_sched
  import el2_lsu_clken_sched_pkg::*;
#(
  parameter int NUM_DOM = 4,
  parameter int HOLD_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_DOM-1:0]   act_i,
  input  logic                 clk_override_i,
  input  logic [HOLD_W-1:0]    cfg_hold_i,
  input  logic                 quiesce_req_i,
  output logic                 quiesce_ack_o,
  output logic [NUM_DOM-1:0]   clken_o,
  output logic                 idle_all_o,
  output el2_lsu_clken_state_t state_o
`ifdef LSU_CLKEN_STATS_EN
  ,
  output logic [NUM_DOM-1:0][15:0] gated_cnt_o
`endif
);

  el2_lsu_clken_state_t state_q, state_d;
  logic                 ack_q, ack_d;
  logic [NUM_DOM-1:0]   busy, cnt_nz, next_zero;
  logic                 drain_done;

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_hold
    el2_lsu_clken_sched_hold #(.HOLD_W(HOLD_W)) u_hold (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .act_i       (act_i[i]),
      .clear_i     (state_q == ST_PARK),
      .load_i      (state_q == ST_WAKE),
      .cfg_hold_i  (cfg_hold_i),
      .busy_o      (busy[i]),
      .cnt_nz_o    (cnt_nz[i]),
      .next_zero_o (next_zero[i])
    );
  end

  assign idle_all_o = ~|act_i & ~|cnt_nz;
  // Park is entered on the first cycle in which every domain would be idle.
  assign drain_done = ~|act_i & (&next_zero);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (quiesce_req_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!quiesce_req_i) state_d = ST_RUN;
                else if (drain_done) state_d = ST_PARK;
      ST_PARK:  if (!quiesce_req_i) state_d = ST_WAKE;
      default:  state_d = ST_RUN;
    endcase
  end

  assign ack_d = (state_d == ST_PARK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Enables are combinational so activity opens the header in the same cycle.
  always_comb begin
    clken_o = busy | {NUM_DOM{clk_override_i}};
    if (rst_i)
      clken_o = act_i | {NUM_DOM{clk_override_i}};
    else if (state_q == ST_PARK)
      clken_o = {NUM_DOM{clk_override_i}};
    else if (state_q == ST_WAKE)
      clken_o = '1;
  end

  assign quiesce_ack_o = ack_q;
  assign state_o       = state_q;

`ifdef LSU_CLKEN_STATS_EN
  logic [NUM_DOM-1:0][15:0] gated_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gated_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++)
        if (!clken_o[i]) gated_q[i] <= sat_inc16(gated_q[i]);
    end
  end

  assign gated_cnt_o = gated_q;
`endif

  act_in_park_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !((state_q == ST_PARK) && (|act_i)));

endmodule
